// File: rtl/ram_dp_clr.sv
// Simple dual-port synchronous RAM with a self-clearing sweep after reset and a read-valid flag.
// Options: RAM_WRITE_BYPASS_EN (write-first same-address read), SIM (debug wires m00..m07).
module ram_dp_clr #(
   parameter int               WIDTH   = 32,
   parameter int               AW      = 6,
   parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
   input  logic             c,
   input  logic             r,
   input  logic [WIDTH-1:0] d,
   input  logic [AW-1:0]    waddr,
   input  logic             we,
   input  logic [AW-1:0]    raddr,
   input  logic             re,
   output logic [WIDTH-1:0] q,
   output logic             qv,
   output logic             busy,
   output logic             wdrop
);
   localparam int          DEPTH     = 1 << AW;
   localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t           state_reg;
   logic [AW:0]      clr_addr_reg;
   logic             busy_reg;
   logic             qv_reg;
   logic             wdrop_reg;
   logic [WIDTH-1:0] ram_q_reg;

   logic [WIDTH-1:0] mem [DEPTH];

   logic             rd_ok;
   logic             mem_we;
   logic [AW-1:0]    mem_wa;
   logic [WIDTH-1:0] mem_wd;

   // The sweep owns the single write port while busy; user writes are refused then.
   always_comb begin
      rd_ok  = !r && !busy_reg && re;
      mem_we = !r && (busy_reg || we);
      mem_wa = busy_reg ? clr_addr_reg[AW-1:0] : waddr;
      mem_wd = busy_reg ? CLR_VAL : d;
   end

   always_ff @(posedge c) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
   end

   always_ff @(posedge c) begin
      if (r) begin
         ram_q_reg <= '0;
      end else if (rd_ok) begin
         ram_q_reg <= mem[raddr];
      end
   end

   always_ff @(posedge c) begin
      if (r) begin
         state_reg    <= CLEAR;
         clr_addr_reg <= '0;
         busy_reg     <= 1'b1;
         qv_reg       <= 1'b0;
         wdrop_reg    <= 1'b0;
      end else begin
         case (state_reg)
            CLEAR: begin
               clr_addr_reg <= clr_addr_reg + 1'b1;
               qv_reg       <= 1'b0;
               wdrop_reg    <= we;
               if (clr_addr_reg == LAST_ADDR) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end
            IDLE: begin
               qv_reg    <= re;
               wdrop_reg <= 1'b0;
            end
            default: begin
               state_reg    <= CLEAR;
               clr_addr_reg <= '0;
               busy_reg     <= 1'b1;
               qv_reg       <= 1'b0;
               wdrop_reg    <= 1'b0;
            end
         endcase
      end
   end

`ifdef RAM_WRITE_BYPASS_EN
   logic             wr_ok;
   logic             byp_reg;
   logic [WIDTH-1:0] byp_d_reg;

   assign wr_ok = !r && !busy_reg && we;

   // Collision flag and write data ride one stage so the RAM read path stays untouched.
   always_ff @(posedge c) begin
      if (r) begin
         byp_reg   <= 1'b0;
         byp_d_reg <= '0;
      end else if (rd_ok) begin
         byp_reg   <= wr_ok && (waddr == raddr);
         byp_d_reg <= d;
      end
   end

   assign q = byp_reg ? byp_d_reg : ram_q_reg;
`else
   assign q = ram_q_reg;
`endif

`ifdef SIM
   if (AW >= 3) begin : g_dbg
      wire [WIDTH-1:0] m00 = mem[0];
      wire [WIDTH-1:0] m01 = mem[1];
      wire [WIDTH-1:0] m02 = mem[2];
      wire [WIDTH-1:0] m03 = mem[3];
      wire [WIDTH-1:0] m04 = mem[4];
      wire [WIDTH-1:0] m05 = mem[5];
      wire [WIDTH-1:0] m06 = mem[6];
      wire [WIDTH-1:0] m07 = mem[7];
   end
`endif

   assign qv    = qv_reg;
   assign busy  = busy_reg;
   assign wdrop = wdrop_reg;
endmodule
